// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, message-locking arbiter that shares one
// serial transmit byte channel among NREQ byte-stream requesters, with a
// one-entry registered output stage and a stalled-owner lock timeout.
module uart_tx_arbiter #(
  parameter int unsigned NREQ         = 3,
  parameter logic [15:0] LOCK_TIMEOUT = 16'd65535
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic [NREQ*8-1:0]       s_data,
  input  logic [NREQ-1:0]         s_valid,
  input  logic [NREQ-1:0]         s_last,
  output logic [NREQ-1:0]         s_ready,
  output logic [7:0]              o_data,
  output logic                    o_valid,
  input  logic                    o_ready,
  output logic [$clog2(NREQ)-1:0] owner,
  output logic                    busy,
  input  logic                    err_clr,
  output logic                    timeout_err
);

  localparam int unsigned OW = $clog2(NREQ);

  typedef enum logic {
    ST_IDLE,
    ST_LOCKED
  } state_e;

  state_e          state_q;
  logic [7:0]      o_data_q;
  logic            o_valid_q;
  logic [OW-1:0]   owner_q;
  logic [15:0]     cnt_q;
  logic            err_q;

  logic            can_take;
  logic [OW-1:0]   cand;
  logic            win_found;
  logic [OW-1:0]   win_idx;
  logic            gnt_vld;
  logic [OW-1:0]   gnt_idx;
  logic [7:0]      gnt_data;
  logic            gnt_last;
  logic [15:0]     cnt_inc;
  logic            lock_expired;

  assign can_take     = ~o_valid_q | o_ready;
  assign cnt_inc      = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
  assign lock_expired = (LOCK_TIMEOUT != 16'd0) && (cnt_inc == LOCK_TIMEOUT);

  // Round-robin scan: first valid requester starting just after the last owner.
  always_comb begin
    win_found = 1'b0;
    win_idx   = owner_q;
    cand      = owner_q;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = OW'((32'(owner_q) + k) % NREQ);
      if (!win_found && s_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Grant selection; only the granted lane's data/last are ever routed onward.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = owner_q;
    if (nrst) begin
      if (state_q == ST_IDLE) begin
        if (win_found && can_take) begin
          gnt_vld = 1'b1;
          gnt_idx = win_idx;
        end
      end else if (s_valid[owner_q] && can_take) begin
        gnt_vld = 1'b1;
        gnt_idx = owner_q;
      end
    end
    s_ready = '0;
    if (gnt_vld) begin
      s_ready[gnt_idx] = 1'b1;
    end
    gnt_data = s_data[32'(gnt_idx)*8 +: 8];
    gnt_last = s_last[gnt_idx];
  end

  // Arbitration FSM, output register stage, lock timeout and sticky error.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= ST_IDLE;
      o_data_q  <= '0;
      o_valid_q <= 1'b0;
      owner_q   <= OW'(NREQ - 1);
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      if (gnt_vld) begin
        o_data_q  <= gnt_data;
        o_valid_q <= 1'b1;
      end else if (o_ready) begin
        o_valid_q <= 1'b0;
      end

      if (err_clr) begin
        err_q <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          if (gnt_vld) begin
            owner_q <= gnt_idx;
            cnt_q   <= '0;
            if (!gnt_last) begin
              state_q <= ST_LOCKED;
            end
          end
        end
        ST_LOCKED: begin
          if (gnt_vld) begin
            cnt_q <= '0;
            if (gnt_last) begin
              state_q <= ST_IDLE;
            end
          end else if (lock_expired) begin
            // owner is kept so the next scan starts after the stalled requester
            state_q <= ST_IDLE;
            err_q   <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_data      = o_data_q;
  assign o_valid     = o_valid_q;
  assign owner       = owner_q;
  assign busy        = (state_q == ST_LOCKED) | o_valid_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (NREQ=3, LOCK_TIMEOUT=8).
module tb_uart_tx_arbiter;

  logic        clk;
  logic        nrst;
  logic [23:0] s_data;
  logic [2:0]  s_valid;
  logic [2:0]  s_last;
  logic [2:0]  s_ready;
  logic [7:0]  o_data;
  logic        o_valid;
  logic        o_ready;
  logic [1:0]  owner;
  logic        busy;
  logic        err_clr;
  logic        timeout_err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0]  vld;
    logic [2:0]  lst;
    logic [23:0] dat;
    logic        ordy;
    logic        eclr;
    logic [2:0]  e_rdy;
    logic        e_ov;
    logic [7:0]  e_od;
    logic [1:0]  e_own;
    logic        e_busy;
    logic        e_err;
  } vec_t;

  vec_t tbl[11];

  uart_tx_arbiter #(
    .NREQ(3),
    .LOCK_TIMEOUT(16'd8)
  ) dut (
    .clk(clk),
    .nrst(nrst),
    .s_data(s_data),
    .s_valid(s_valid),
    .s_last(s_last),
    .s_ready(s_ready),
    .o_data(o_data),
    .o_valid(o_valid),
    .o_ready(o_ready),
    .owner(owner),
    .busy(busy),
    .err_clr(err_clr),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called just after a posedge: drive, check s_ready, clock, check outputs.
  task automatic run_vec(input vec_t v, input string nm);
    s_valid = v.vld;
    s_last  = v.lst;
    s_data  = v.dat;
    o_ready = v.ordy;
    err_clr = v.eclr;
    #1;
    chk({nm, ".s_ready"}, 32'(s_ready), 32'(v.e_rdy));
    @(posedge clk);
    #1;
    chk({nm, ".o_valid"}, 32'(o_valid), 32'(v.e_ov));
    chk({nm, ".o_data"}, 32'(o_data), 32'(v.e_od));
    chk({nm, ".owner"}, 32'(owner), 32'(v.e_own));
    chk({nm, ".busy"}, 32'(busy), 32'(v.e_busy));
    chk({nm, ".timeout_err"}, 32'(timeout_err), 32'(v.e_err));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // round-robin, then locked message with a pending competitor
    tbl[0]  = '{3'b111, 3'b111, 24'h706041, 1'b1, 1'b0, 3'b001, 1'b1, 8'h41, 2'd0, 1'b1, 1'b0};
    tbl[1]  = '{3'b111, 3'b111, 24'h706041, 1'b1, 1'b0, 3'b010, 1'b1, 8'h60, 2'd1, 1'b1, 1'b0};
    tbl[2]  = '{3'b111, 3'b111, 24'h706041, 1'b1, 1'b0, 3'b100, 1'b1, 8'h70, 2'd2, 1'b1, 1'b0};
    tbl[3]  = '{3'b111, 3'b111, 24'h706041, 1'b1, 1'b0, 3'b001, 1'b1, 8'h41, 2'd0, 1'b1, 1'b0};
    tbl[4]  = '{3'b100, 3'b111, 24'h706041, 1'b1, 1'b0, 3'b100, 1'b1, 8'h70, 2'd2, 1'b1, 1'b0};
    tbl[5]  = '{3'b011, 3'b010, 24'h706048, 1'b1, 1'b0, 3'b001, 1'b1, 8'h48, 2'd0, 1'b1, 1'b0};
    tbl[6]  = '{3'b011, 3'b010, 24'h706049, 1'b1, 1'b0, 3'b001, 1'b1, 8'h49, 2'd0, 1'b1, 1'b0};
    tbl[7]  = '{3'b011, 3'b011, 24'h70600A, 1'b1, 1'b0, 3'b001, 1'b1, 8'h0A, 2'd0, 1'b1, 1'b0};
    tbl[8]  = '{3'b011, 3'b011, 24'h706050, 1'b1, 1'b0, 3'b010, 1'b1, 8'h60, 2'd1, 1'b1, 1'b0};
    tbl[9]  = '{3'b001, 3'b011, 24'h706050, 1'b1, 1'b0, 3'b001, 1'b1, 8'h50, 2'd0, 1'b1, 1'b0};
    tbl[10] = '{3'b000, 3'b000, 24'h000000, 1'b1, 1'b0, 3'b000, 1'b0, 8'h50, 2'd0, 1'b0, 1'b0};

    nrst    = 1'b0;
    s_valid = '0;
    s_last  = '0;
    s_data  = '0;
    o_ready = 1'b0;
    err_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.o_valid", 32'(o_valid), 32'd0);
    chk("rst.o_data", 32'(o_data), 32'h00);
    chk("rst.s_ready", 32'(s_ready), 32'd0);
    chk("rst.owner", 32'(owner), 32'd2);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.timeout_err", 32'(timeout_err), 32'd0);
    nrst = 1'b1;

    for (int i = 0; i < 11; i++) begin
      run_vec(tbl[i], $sformatf("tbl%0d", i));
    end

    // back-pressure hold, then handshake-out plus new accept in one cycle
    run_vec('{3'b010, 3'b010, 24'h005500, 1'b1, 1'b0, 3'b010, 1'b1, 8'h55, 2'd1, 1'b1, 1'b0}, "bp_load");
    for (int i = 0; i < 10; i++) begin
      run_vec('{3'b100, 3'b100, 24'h770000, 1'b0, 1'b0, 3'b000, 1'b1, 8'h55, 2'd1, 1'b1, 1'b0},
              $sformatf("bp_hold%0d", i));
    end
    run_vec('{3'b100, 3'b100, 24'h77xxxx, 1'b1, 1'b0, 3'b100, 1'b1, 8'h77, 2'd2, 1'b1, 1'b0}, "bp_release");
    run_vec('{3'b000, 3'b000, 24'h000000, 1'b1, 1'b0, 3'b000, 1'b0, 8'h77, 2'd2, 1'b0, 1'b0}, "bp_drain");

    // lock timeout: req1 stalls mid-message while req0 waits
    run_vec('{3'b010, 3'b000, 24'h003300, 1'b1, 1'b0, 3'b010, 1'b1, 8'h33, 2'd1, 1'b1, 1'b0}, "to_lock");
    for (int i = 1; i <= 7; i++) begin
      run_vec('{3'b001, 3'b001, 24'h000044, 1'b1, 1'b0, 3'b000, 1'b0, 8'h33, 2'd1, 1'b1, 1'b0},
              $sformatf("to_stall%0d", i));
    end
    run_vec('{3'b001, 3'b001, 24'h000044, 1'b1, 1'b0, 3'b000, 1'b0, 8'h33, 2'd1, 1'b0, 1'b1}, "to_expire");
    run_vec('{3'b001, 3'b001, 24'h000044, 1'b1, 1'b0, 3'b001, 1'b1, 8'h44, 2'd0, 1'b1, 1'b1}, "to_regrant");
    run_vec('{3'b000, 3'b000, 24'h000000, 1'b1, 1'b1, 3'b000, 1'b0, 8'h44, 2'd0, 1'b0, 1'b0}, "to_errclr");

    // asynchronous reset while locked with a byte held in the output stage
    run_vec('{3'b100, 3'b000, 24'h5A0000, 1'b1, 1'b0, 3'b100, 1'b1, 8'h5A, 2'd2, 1'b1, 1'b0}, "mr_lock");
    s_valid = 3'b111;
    s_last  = 3'b111;
    s_data  = 24'h706041;
    o_ready = 1'b0;
    #1;
    chk("mr_stall.s_ready", 32'(s_ready), 32'd0);
    #2;
    nrst = 1'b0;
    #1;
    chk("mr_rst.o_valid", 32'(o_valid), 32'd0);
    chk("mr_rst.s_ready", 32'(s_ready), 32'd0);
    chk("mr_rst.o_data", 32'(o_data), 32'h00);
    chk("mr_rst.owner", 32'(owner), 32'd2);
    chk("mr_rst.busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    nrst = 1'b1;
    run_vec('{3'b111, 3'b111, 24'h706041, 1'b1, 1'b0, 3'b001, 1'b1, 8'h41, 2'd0, 1'b1, 1'b0}, "mr_first");

    // only req2 valid: wrap-around scan grants it every cycle
    for (int i = 0; i < 5; i++) begin
      run_vec('{3'b100, 3'b100, 24'h700000, 1'b1, 1'b0, 3'b100, 1'b1, 8'h70, 2'd2, 1'b1, 1'b0},
              $sformatf("wrap%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
